// File: rtl/msg_uart_pkg.sv
// Shared types and constants for the message UART transmitter.
// Optional feature macro: MSG_UART_TX_PARITY_EN (adds an even-parity bit).
package msg_uart_pkg;

  localparam int unsigned UART_DATA_BITS       = 8;
  localparam int unsigned UART_DEFAULT_DIVISOR = 4;

`ifdef MSG_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } uart_state_t;
`endif

endpackage

// File: rtl/msg_byte_fifo.sv
// Small synchronous FIFO: registered pointers, head word read combinationally.
// Full is judged on the current occupancy, so a same-cycle pop never opens a slot.
module msg_byte_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/msg_uart_tx.sv
// Buffered UART transmitter: FIFO in front of an 8N1 serializer.
// Optional feature macro: MSG_UART_TX_PARITY_EN (even parity, 11-bit frame).
module msg_uart_tx
  import msg_uart_pkg::*;
#(
  parameter int unsigned DIVISOR    = UART_DEFAULT_DIVISOR,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned BAUD_W = $clog2(DIVISOR);
  localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(DIVISOR - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(UART_DATA_BITS - 1);

  uart_state_t         state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [7:0]          shift_reg;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [7:0]          fifo_rd_data;
  logic                baud_zero;
`ifdef MSG_UART_TX_PARITY_EN
  logic                parity_bit;
`endif

  assign in_ready  = !fifo_full;
  assign baud_zero = (baud_cnt == '0);
  // Pops happen on the IDLE edge or on the last STOP cycle so frames stay contiguous.
  assign fifo_pop  = !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_STOP) && baud_zero));

  msg_byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid && in_ready),
    .wr_data (in_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // Frame sequencer: baud timing, bit shifting and registered tx/busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
`ifdef MSG_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shift_reg <= fifo_rd_data;
`ifdef MSG_UART_TX_PARITY_EN
            parity_bit <= ^fifo_rd_data;
`endif
            bit_cnt   <= '0;
            baud_cnt  <= BAUD_RELOAD;
            tx        <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (baud_zero) begin
            baud_cnt  <= BAUD_RELOAD;
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_zero) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_cnt == BIT_LAST) begin
`ifdef MSG_UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= ST_PARITY;
`else
              tx    <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`ifdef MSG_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_zero) begin
            baud_cnt <= BAUD_RELOAD;
            tx       <= 1'b1;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (baud_zero) begin
            baud_cnt <= BAUD_RELOAD;
            if (!fifo_empty) begin
              shift_reg <= fifo_rd_data;
`ifdef MSG_UART_TX_PARITY_EN
              parity_bit <= ^fifo_rd_data;
`endif
              bit_cnt   <= '0;
              tx        <= 1'b0;
              state     <= ST_START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_uart_tx.sv
// Directed bench for msg_uart_tx with a byte scoreboard fed at push time and
// drained by a serial-line decoder.
module tb_msg_uart_tx;

  localparam int unsigned D     = 4;
  localparam int unsigned DEPTH = 16;
`ifdef MSG_UART_TX_PARITY_EN
  localparam int unsigned FB = 11;
`else
  localparam int unsigned FB = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [$clog2(DEPTH):0] level;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic       mon_en = 1'b0;
  logic [7:0] mon_got;
  logic [8:0] mon_exp;
  int         accepted;
  int         guard;
  int         busy_cnt;
  int         lvl_max;
  int         all_rdy;
  logic [103:0] msg_bits;
  logic [10:0]  frame;

  msg_uart_tx #(
    .DIVISOR    (D),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    sb.push_back(b);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drive_cycle();
    logic acc;
    acc = in_valid && in_ready;
    step();
    if (acc) begin
      sb.push_back(in_data);
      accepted++;
      in_data = in_data + 8'd1;
    end
  endtask

  // Serial decoder: samples the middle of every bit and retires scoreboard entries.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
        repeat (D / 2) @(negedge clk);
        check("mon_start", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (D) @(negedge clk);
          mon_got[i] = tx;
        end
`ifdef MSG_UART_TX_PARITY_EN
        repeat (D) @(negedge clk);
        check("mon_parity", {31'd0, tx}, {31'd0, ^mon_got});
`endif
        repeat (D) @(negedge clk);
        check("mon_stop", {31'd0, tx}, 32'd1);
        mon_exp = (sb.size() > 0) ? {1'b0, sb.pop_front()} : 9'h100;
        check("mon_byte", {24'd0, mon_got}, {23'd0, mon_exp});
        repeat (D - D / 2 - 1) @(negedge clk);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) step();
    #2 rst_n = 1'b1;

    // Idle after reset.
    for (int c = 0; c < 100; c++) begin
      step();
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      check("rst_level", {27'd0, level}, 32'd0);
    end

    // Single byte 0x68: cycle-exact frame shape.
    mon_en = 1'b1;
`ifdef MSG_UART_TX_PARITY_EN
    frame = {1'b1, ^8'h68, 8'h68, 1'b0};
`else
    frame = {1'b0, 1'b1, 8'h68, 1'b0};
`endif
    push_byte(8'h68);
    check("lat_level1", {27'd0, level}, 32'd1);
    check("lat_tx_hi", {31'd0, tx}, 32'd1);
    check("lat_busy_lo", {31'd0, busy}, 32'd0);
    step();
    check("pop_level0", {27'd0, level}, 32'd0);
    for (int c = 0; c < int'(FB * D); c++) begin
      check("frame_tx", {31'd0, tx}, {31'd0, frame[c / D]});
      check("frame_busy", {31'd0, busy}, 32'd1);
      step();
    end
    check("frame_end_busy", {31'd0, busy}, 32'd0);
    check("frame_end_tx", {31'd0, tx}, 32'd1);
    repeat (4) step();
    check("sb_empty_single", sb.size(), 32'd0);

    // "hello world!\n" back to back.
    msg_bits = "hello world!\n";
    busy_cnt = 0;
    lvl_max  = 0;
    all_rdy  = 1;
    for (int i = 0; i < 13; i++) begin
      in_data  = msg_bits[8 * (12 - i) +: 8];
      in_valid = 1'b1;
      if (in_ready !== 1'b1) all_rdy = 0;
      else sb.push_back(in_data);
      step();
      if (busy === 1'b1) busy_cnt++;
      if (int'(level) > lvl_max) lvl_max = int'(level);
    end
    in_valid = 1'b0;
    check("hello_accepted", all_rdy, 32'd1);
    check("hello_level_peak", lvl_max, 32'd12);
    guard = 0;
    while (busy === 1'b1 && guard < 2000) begin
      step();
      guard++;
      if (busy === 1'b1) busy_cnt++;
    end
    check("hello_busy_cycles", busy_cnt, 13 * FB * D);
    repeat (4) step();
    check("sb_empty_hello", sb.size(), 32'd0);

    // Continuous valid: fill, then one-slot reopenings.
    accepted = 0;
    in_data  = 8'h30;
    in_valid = 1'b1;
    guard    = 0;
    while (in_ready === 1'b1 && guard < 100) begin
      drive_cycle();
      guard++;
    end
    check("fill_accepted", accepted, DEPTH + 1);
    check("fill_level", {27'd0, level}, DEPTH);
    for (int k = 0; k < 2; k++) begin
      guard = 0;
      while (in_ready !== 1'b1 && guard < 100) begin
        drive_cycle();
        guard++;
      end
      check("reopen_ready", {31'd0, in_ready}, 32'd1);
      check("reopen_level", {27'd0, level}, DEPTH - 1);
      if (k == 1) check("reopen_gap", guard, FB * D - 1);
      drive_cycle();
      check("reopen_one_cycle", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    guard = 0;
    while ((busy !== 1'b0 || level !== '0) && guard < 5000) begin
      step();
      guard++;
    end
    repeat (4) step();
    check("drain_busy", {31'd0, busy}, 32'd0);
    check("sb_empty_flow", sb.size(), 32'd0);

    // Asynchronous reset in mid-DATA with 5 bytes waiting.
    mon_en = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'hC0 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (8) step();
    check("pre_rst_level", {27'd0, level}, 32'd5);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_tx", {31'd0, tx}, 32'd1);
    check("async_level", {27'd0, level}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) step();
    #3 rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      check("post_rst_tx", {31'd0, tx}, 32'd1);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
    end

    mon_en = 1'b1;
    push_byte(8'hA5);
    guard = 0;
    while ((busy !== 1'b0 || level !== '0) && guard < 1000) begin
      step();
      guard++;
    end
    repeat (4) step();
    check("sb_empty_final", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
